// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and engine state encoding.
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5,
        ST_DRAIN = 3'd6
    } state_e;

endpackage

// File: rtl/axil_master_engine_if.sv
// AXI4-Lite bus bundle between the master engine and a register slave.
interface axil_master_engine_if #(
    parameter int unsigned AW = 8
);

    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axil_master_engine.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back. A watchdog answers with SLVERR on a hung slave and then
// drains the late handshake so the bus never sees a retracted VALID.
module axil_master_engine
    import axil_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic                 rsp_timeout,
    output logic                 busy,

    axil_master_engine_if.master m_axi
);

    localparam int unsigned   CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] WD_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;

    state_e        state;
    logic          is_write;
    logic          aw_done;
    logic          w_done;
    logic          ar_done;
    logic          x_done;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          bready_q;
    logic          arvalid_q;
    logic          rready_q;
    logic [CW-1:0] wd_cnt;

    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          ar_hs;
    logic          r_hs;
    logic          in_axi;
    logic          wd_hit;
    logic          drained;
    logic          rsp_free;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    // Handshake decode, watchdog expiry and drain completion for this cycle.
    always_comb begin
        aw_hs    = awvalid_q & m_axi.awready;
        w_hs     = wvalid_q  & m_axi.wready;
        b_hs     = bready_q  & m_axi.bvalid;
        ar_hs    = arvalid_q & m_axi.arready;
        r_hs     = rready_q  & m_axi.rvalid;
        in_axi   = (state == ST_WADDR) || (state == ST_WRESP) ||
                   (state == ST_RADDR) || (state == ST_RDATA);
        wd_hit   = WD_EN && in_axi && (wd_cnt == WD_LAST);
        drained  = is_write ? ((aw_done | aw_hs) & (w_done | w_hs) & (x_done | b_hs))
                            : ((ar_done | ar_hs) & (x_done | r_hs));
        rsp_free = ~rsp_valid | rsp_ready;
    end

    // Engine FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= OKAY;
            rsp_timeout <= 1'b0;
            is_write    <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            ar_done     <= 1'b0;
            x_done      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            // Each channel retires on its own handshake, whatever the state.
            if (aw_hs) begin
                awvalid_q <= 1'b0;
                aw_done   <= 1'b1;
            end
            if (w_hs) begin
                wvalid_q <= 1'b0;
                w_done   <= 1'b1;
            end
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                ar_done   <= 1'b1;
            end
            if (b_hs) begin
                bready_q <= 1'b0;
                x_done   <= 1'b1;
            end
            if (r_hs) begin
                rready_q <= 1'b0;
                x_done   <= 1'b1;
            end
            if (in_axi && (wd_cnt != '1)) begin
                wd_cnt <= wd_cnt + CW'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        is_write    <= cmd_write;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        ar_done     <= 1'b0;
                        x_done      <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= OKAY;
                        rsp_timeout <= 1'b0;
                        // The accept cycle is the first watchdog cycle.
                        wd_cnt      <= CW'(1);
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= ST_WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_RADDR;
                        end
                    end
                end
                ST_WADDR: begin
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state    <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (b_hs) begin
                        rsp_valid <= 1'b1;
                        rsp_resp  <= m_axi.bresp;
                        rsp_rdata <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_RADDR: begin
                    if (ar_hs) begin
                        rready_q <= 1'b1;
                        state    <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        rsp_valid <= 1'b1;
                        rsp_resp  <= m_axi.rresp;
                        rsp_rdata <= m_axi.rdata;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    if (drained && rsp_free) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Watchdog expiry overrides normal progress unless the real response lands now.
            if (wd_hit && !(b_hs || r_hs)) begin
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_resp    <= SLVERR;
                rsp_rdata   <= '0;
                bready_q    <= is_write;
                rready_q    <= ~is_write;
                state       <= ST_DRAIN;
            end
        end
    end

endmodule
